// File: rtl/prescaled_counter_pkg.sv
// -----------------------------------------------------------------------------
// prescaled_counter_pkg
//
// Shared definitions for the prescaled counter slice:
//   DEFAULT_WIDTH  default counter width in bits
//   DEFAULT_DIV    default prescale ratio (clk cycles per count step)
//   clog2_min1()   ceil(log2(value)), never less than 1; sizes the prescaler
//
// Optional feature macro used by this slice: PRESCALED_COUNTER_SAT_EN
// (saturating count instead of wrap-around; see prescaled_counter.sv).
// -----------------------------------------------------------------------------
package prescaled_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 50000000;

  // Number of bits needed to hold values 0..value-1. A prescaler with
  // DIV = 1 never leaves 0, but still needs a one-bit register to exist.
  function automatic int clog2_min1(input longint unsigned value);
    int bits;
    bits = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) begin
        bits = i + 1;
      end
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/prescaled_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Prescaler for prescaled_counter. Counts 0..DIV-1 on enabled cycles and
// raises a combinational step strobe on the enabled cycle in which the
// prescaler sits at DIV-1, so the owning edge both wraps the prescaler and
// advances the counter. The step period is exactly DIV enabled cycles.
//
// Parameters:
//   DIV    prescale ratio, >= 1
//
// Ports:
//   clk    input   clock, rising edge
//   reset  input   synchronous, active-high; prescaler -> 0
//   en     input   enable; low holds the prescaler value
//   clr    input   synchronous clear; prescaler -> 0 regardless of en
//   step   output  high when the coming edge is a count step edge
// -----------------------------------------------------------------------------
module tick_gen
  import prescaled_counter_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int            PW   = clog2_min1(longint'(DIV));
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic          at_last;

  assign at_last = (pcnt == LAST);

  // Wrap on DIV-1 rather than on DIV so the period is DIV, not DIV+1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (at_last) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // With DIV = 1 the prescaler is pinned at 0 == LAST, so every enabled
  // cycle is a step.
  assign step = en & at_last;

endmodule

// File: rtl/prescaled_counter.sv
// -----------------------------------------------------------------------------
// prescaled_counter
//
// Up/down counter that advances once every DIV enabled clock cycles. The
// prescaler lives in tick_gen; this module owns count, tick and tc.
//
// Parameters:
//   WIDTH  counter width in bits (1..32)
//   DIV    clk cycles per count step (>= 1)
//
// Ports:
//   clk       input          clock, all logic on its rising edge
//   reset     input          synchronous, active-high; overrides load and en
//   en        input          enable; low freezes prescaler and count
//   up_dn     input          1 = increment, 0 = decrement (sampled on step)
//   load      input          synchronous load; beats a coincident step
//   load_val  input  [W-1:0] value loaded into count
//   count     output [W-1:0] current count, registered
//   tick      output         one-cycle pulse after each step edge, registered
//   tc        output         one-cycle terminal-count pulse with tick
//
// Build option:
//   PRESCALED_COUNTER_SAT_EN  when defined the count saturates at the
//   boundaries (holds all-ones going up, zero going down). The blocked step
//   still pulses tick, and tc as it is a boundary step. When undefined the
//   count wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic             step;
  logic             at_boundary;
  logic [WIDTH-1:0] count_nxt;

  // A load also restarts the prescale interval, so the first step after a
  // load lands exactly DIV enabled cycles later.
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .step  (step)
  );

  // A step "crosses a boundary" when it would leave the representable range
  // in the current direction: up from all-ones or down from zero.
  always_comb begin
    at_boundary = 1'b0;
    count_nxt   = count;
    if (up_dn) begin
      at_boundary = (count == COUNT_MAX);
    end else begin
      at_boundary = (count == '0);
    end
`ifdef PRESCALED_COUNTER_SAT_EN
    if (!at_boundary) begin
      count_nxt = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    end
`else
    count_nxt = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
`endif
  end

  // Priority: reset, then load (discarding any coincident step), then step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (step) begin
      count <= count_nxt;
      tick  <= 1'b1;
      tc    <= at_boundary;
    end else begin
      tick  <= 1'b0;
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_counter
//
// Drives three instances from shared stimulus:
//   u_dut4  WIDTH=4, DIV=4
//   u_dut1  WIDTH=4, DIV=1
//   u_dflt  default WIDTH/DIV, free running (must stay silent for the whole
//           run, the first tick being 50,000,000 cycles away)
// Expected values come from an arithmetic model of the counter rules.
// -----------------------------------------------------------------------------
module tb_prescaled_counter;

  // ---------------------------------------------------------------- clock/reset
  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [3:0] c4, c1;
  logic       tick4, tc4, tick1, tc1;
  logic [7:0] cd;
  logic       tickd, tcd;

  prescaled_counter #(.WIDTH(4), .DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(c4), .tick(tick4), .tc(tc4)
  );

  prescaled_counter #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(c1), .tick(tick1), .tc(tc1)
  );

  prescaled_counter u_dflt (
    .clk(clk), .reset(reset), .en(1'b1), .up_dn(1'b1), .load(1'b0),
    .load_val(8'h00), .count(cd), .tick(tickd), .tc(tcd)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Per instance: count as an integer, elapsed enabled cycles in the current
  // prescale interval, and the outputs expected after the last edge.
  int          m_cnt [2];
  int          m_ph  [2];
  bit          m_tick[2];
  bit          m_tc  [2];
  int          m_div [2] = '{4, 1};
  logic [3:0]  exp_q[$];

  task automatic model_edge(input bit r, input bit e, input bit u,
                            input bit l, input int lv);
    int raw;
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 0;
      m_tc[k]   = 0;
      if (r) begin
        m_cnt[k] = 0;
        m_ph[k]  = 0;
      end else if (l) begin
        m_cnt[k] = lv;
        m_ph[k]  = 0;
      end else if (e) begin
        m_ph[k] = m_ph[k] + 1;
        if (m_ph[k] == m_div[k]) begin
          m_ph[k]   = 0;
          m_tick[k] = 1;
          raw = m_cnt[k] + (u ? 1 : -1);
          if (raw < 0 || raw > 15) begin
            m_tc[k] = 1;
`ifdef PRESCALED_COUNTER_SAT_EN
            raw = m_cnt[k];
`else
            raw = (raw + 16) % 16;
`endif
          end
          m_cnt[k] = raw;
        end
      end
    end
    exp_q.push_back(4'(m_cnt[0]));
  endtask

  // ---------------------------------------------------------------- driver
  int tick4_seen = 0;
  int tc4_seen   = 0;
  int dflt_seen  = 0;

  task automatic run_cycle(input bit r, input bit e, input bit u,
                           input bit l, input logic [3:0] lv);
    logic [3:0] exp_c;
    reset    = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = lv;
    @(posedge clk);
    model_edge(r, e, u, l, int'(lv));
    #1;
    exp_c = exp_q.pop_front();
    check_eq("count4", 32'(c4), 32'(exp_c));
    check_eq("tick4", 32'(tick4), 32'(m_tick[0]));
    check_eq("tc4", 32'(tc4), 32'(m_tc[0]));
    check_eq("count1", 32'(c1), 32'(m_cnt[1]));
    check_eq("tick1", 32'(tick1), 32'(m_tick[1]));
    check_eq("tc1", 32'(tc1), 32'(m_tc[1]));
    tick4_seen += int'(tick4);
    tc4_seen   += int'(tc4);
    if (tickd || tcd) dflt_seen++;
  endtask

  task automatic run_n(input int n, input bit e, input bit u);
    for (int i = 0; i < n; i++) run_cycle(1'b0, e, u, 1'b0, 4'h0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'h0;

    // Reset state
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
    check_eq("reset_count", 32'(c4), 32'd0);
    check_eq("reset_tick", 32'(tick4), 32'd0);
    check_eq("reset_tc", 32'(tc4), 32'd0);

    // Full up-count lap: 16 steps in 64 cycles, a single tc
    tick4_seen = 0; tc4_seen = 0;
    run_n(64, 1'b1, 1'b1);
    check_eq("lap_ticks", 32'(tick4_seen), 32'd16);
    check_eq("lap_tc", 32'(tc4_seen), 32'd1);

    // en dropped after two enabled cycles, prescaler held
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    run_n(2, 1'b1, 1'b1);
    run_n(10, 1'b0, 1'b1);
    check_eq("frozen_count", 32'(c4), 32'd0);
    run_n(1, 1'b1, 1'b1);
    check_eq("resume_no_tick", 32'(tick4), 32'd0);
    run_n(1, 1'b1, 1'b1);
    check_eq("resume_tick", 32'(tick4), 32'd1);
    check_eq("resume_count", 32'(c4), 32'd1);

    // Load coincident with a step edge
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    run_n(3, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    check_eq("load_count", 32'(c4), 32'hA);
    check_eq("load_tick", 32'(tick4), 32'd0);
    tick4_seen = 0;
    run_n(3, 1'b1, 1'b1);
    check_eq("load_quiet", 32'(tick4_seen), 32'd0);
    run_n(1, 1'b1, 1'b1);
    check_eq("load_next_tick", 32'(tick4), 32'd1);
    check_eq("load_next_count", 32'(c4), 32'hB);

    // Down from zero with DIV=1
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    run_n(1, 1'b1, 1'b0);
`ifdef PRESCALED_COUNTER_SAT_EN
    check_eq("down0_count", 32'(c1), 32'd0);
`else
    check_eq("down0_count", 32'(c1), 32'd15);
`endif
    check_eq("down0_tick", 32'(tick1), 32'd1);
    check_eq("down0_tc", 32'(tc1), 32'd1);

    // Reset mid-interval at count 7
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    run_n(2, 1'b1, 1'b1);
    check_eq("pre_reset_count", 32'(c4), 32'd7);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("mid_reset_count", 32'(c4), 32'd0);
    check_eq("mid_reset_tick", 32'(tick4), 32'd0);
    check_eq("mid_reset_tc", 32'(tc4), 32'd0);
    tick4_seen = 0;
    run_n(3, 1'b1, 1'b1);
    check_eq("post_reset_quiet", 32'(tick4_seen), 32'd0);
    run_n(1, 1'b1, 1'b1);
    check_eq("post_reset_tick", 32'(tick4), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 8,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 24) == 0,
                4'($urandom_range(0, 15)));
    end

    // Default build never reaches its first step within this run
    check_eq("dflt_silent", 32'(dflt_seen), 32'd0);
    check_eq("dflt_count", 32'(cd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
